// File: rtl/axi_mem_write_slave_if.sv
// AXI4 write-channel bundle (AW, W, B) between a write master and the memory responder.
// Signal names follow the AXI channel names; clock and reset travel as plain ports.
`default_nettype none

interface axi_mem_write_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY
  );
endinterface

`default_nettype wire

// File: rtl/axi_mem_write_slave.sv
// ---------------------------------------------------------------------------
// axi_mem_write_slave : AXI4 write responder storing bursts into a strobed word RAM.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module axi_mem_write_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  wire logic                         ACLK,
  input  wire logic                         ARESETn,
  axi_mem_write_slave_if.slave              s_axi,
  input  wire logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic      [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int LANE_SHIFT = $clog2(STRB_W);
  localparam int IDX_W      = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [8:0]            r_beat_cnt;
  logic                  r_err;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] w_size_bytes;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_in_range;
  logic                  w_beat;
  logic                  w_final;
  logic                  w_err_next;
  logic                  w_mem_we;
  logic [IDX_W-1:0]      w_mem_idx;
  logic                  w_aw_err;

  assign w_size_bytes = ADDR_WIDTH'(1) << r_size;
  // INCR aligns to the beat size after the first (possibly unaligned) beat
  assign w_next_addr  = (r_burst == 2'b01) ? ((r_addr & ~(w_size_bytes - 1'b1)) + w_size_bytes)
                                           : r_addr;
  // Addresses below BASE_ADDR wrap to huge offsets and land out of range
  assign w_word       = (r_addr - BASE_ADDR) >> LANE_SHIFT;
  assign w_in_range   = (w_word < ADDR_WIDTH'(MEM_DEPTH));
  assign w_mem_idx    = w_word[IDX_W-1:0];
  assign w_beat       = s_axi.WVALID && r_wready;
  assign w_final      = (r_beat_cnt == {1'b0, r_len});
  assign w_err_next   = r_err || !w_in_range || (s_axi.WLAST != w_final);
  assign w_mem_we     = w_beat && w_in_range && !r_err;
  assign w_aw_err     = s_axi.AWBURST[1] || (s_axi.AWSIZE > 3'(LANE_SHIFT));

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BRESP   = r_bresp;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
      r_awready  <= 1'b1;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_axi.AWVALID && r_awready) begin
            r_addr     <= s_axi.AWADDR;
            r_len      <= s_axi.AWLEN;
            r_size     <= s_axi.AWSIZE;
            r_burst    <= s_axi.AWBURST;
            r_beat_cnt <= '0;
            r_err      <= w_aw_err;
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_err <= w_err_next;
            if (w_final) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_err_next ? 2'b10 : 2'b00;
              r_state  <= S_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 9'd1;
              r_addr     <= w_next_addr;
            end
          end
        end
        S_RESP: begin
          if (s_axi.BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_awready <= 1'b1;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // RAM has no reset so beats written before a reset survive it
  always_ff @(posedge ACLK) begin
    if (w_mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi.WSTRB[i]) begin
          r_mem[w_mem_idx][i*8 +: 8] <= s_axi.WDATA[i*8 +: 8];
        end
      end
    end
  end

  assign dbg_rdata = r_mem[dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_axi_mem_write_slave.sv
// Directed bench for axi_mem_write_slave: drives AW/W/B through the interface and
// checks handshakes, responses and RAM contents via the backdoor read port.
`default_nettype none

module tb_axi_mem_write_slave;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int LIMIT = 50;

  logic             ACLK = 1'b0;
  logic             ARESETn = 1'b0;
  logic [9:0]       dbg_addr;
  logic [DW-1:0]    dbg_rdata;
  int               checks = 0;
  int               errors = 0;

  always #5 ACLK = ~ACLK;

  axi_mem_write_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_mem_write_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(32'h0)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .s_axi    (bus.slave),
    .dbg_addr (dbg_addr),
    .dbg_rdata(dbg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s timeout observed=waiting expected=handshake", tag);
  endtask

  task automatic ram_chk(input string tag, input int idx, input logic [31:0] exp);
    dbg_addr = 10'(idx);
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  task automatic aw(input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    while (!bus.AWREADY && n < LIMIT) begin @(posedge ACLK); #1; n++; end
    if (n == LIMIT) timeout("aw");
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last;
    bus.WVALID = 1'b1;
    while (!bus.WREADY && n < LIMIT) begin @(posedge ACLK); #1; n++; end
    if (n == LIMIT) timeout("w");
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
  endtask

  task automatic b(input string tag, input logic [1:0] exp_resp);
    int n = 0;
    bus.BREADY = 1'b1;
    while (!bus.BVALID && n < LIMIT) begin @(posedge ACLK); #1; n++; end
    if (n == LIMIT) timeout(tag);
    chk({tag, "_bresp"}, 32'(bus.BRESP), 32'(exp_resp));
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0;
    chk({tag, "_bvalid_drop"}, 32'(bus.BVALID), 32'd0);
    chk({tag, "_awready_back"}, 32'(bus.AWREADY), 32'd1);
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    dbg_addr = '0;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    chk("rst_awready", 32'(bus.AWREADY), 32'd1);
    chk("rst_wready",  32'(bus.WREADY),  32'd0);
    chk("rst_bvalid",  32'(bus.BVALID),  32'd0);
    chk("rst_bresp",   32'(bus.BRESP),   32'd0);

    // T1 single beat
    aw(32'h10, 8'd0, 3'd2, 2'b01);
    chk("t1_wready_after_aw", 32'(bus.WREADY), 32'd1);
    chk("t1_awready_low", 32'(bus.AWREADY), 32'd0);
    w(32'hDEADBEEF, 4'hF, 1'b1);
    chk("t1_bvalid_next", 32'(bus.BVALID), 32'd1);
    chk("t1_wready_low", 32'(bus.WREADY), 32'd0);
    b("t1", 2'b00);
    ram_chk("t1_ram4", 4, 32'hDEADBEEF);

    // T2 INCR len3 with WVALID gaps
    aw(32'h0, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      repeat (2) begin @(posedge ACLK); #1; end
      w(32'(i + 1), 4'hF, i == 3);
      if (i == 2) begin
        chk("t2_no_early_b", 32'(bus.BVALID), 32'd0);
        chk("t2_still_ready", 32'(bus.WREADY), 32'd1);
      end
    end
    chk("t2_wready_done", 32'(bus.WREADY), 32'd0);
    b("t2", 2'b00);
    for (int i = 0; i < 4; i++) ram_chk($sformatf("t2_ram%0d", i), i, 32'(i + 1));

    // T3 byte strobes, then FIXED burst
    aw(32'h14, 8'd0, 3'd2, 2'b01);
    w(32'h11223344, 4'hF, 1'b1);
    b("t3a", 2'b00);
    aw(32'h14, 8'd0, 3'd2, 2'b01);
    w(32'hAABBCCDD, 4'b0101, 1'b1);
    b("t3b", 2'b00);
    ram_chk("t3_strb0101", 5, 32'h11BB33DD);
    aw(32'h14, 8'd0, 3'd2, 2'b01);
    w(32'h99000000, 4'b1000, 1'b1);
    b("t3c", 2'b00);
    ram_chk("t3_strb1000", 5, 32'h99BB33DD);
    aw(32'h8, 8'd2, 3'd2, 2'b00);
    w(32'hA1, 4'hF, 1'b0);
    w(32'hA2, 4'hF, 1'b0);
    w(32'hA3, 4'hF, 1'b1);
    b("t3d", 2'b00);
    ram_chk("t3_fixed_ram2", 2, 32'hA3);
    ram_chk("t3_fixed_ram3", 3, 32'h4);
    ram_chk("t3_fixed_ram1", 1, 32'h2);

    // T4 burst runs off the top of RAM
    aw(32'(DEPTH * 4 - 4), 8'd1, 3'd2, 2'b01);
    w(32'h55, 4'hF, 1'b0);
    w(32'h66, 4'hF, 1'b1);
    b("t4", 2'b10);
    ram_chk("t4_top", DEPTH - 1, 32'h55);
    ram_chk("t4_no_wrap", 0, 32'h1);

    // T5 unsupported burst, oversize beat, WLAST errors
    aw(32'h0, 8'd1, 3'd2, 2'b10);
    w(32'h77, 4'hF, 1'b0);
    chk("t5_consumes_2", 32'(bus.BVALID), 32'd0);
    w(32'h88, 4'hF, 1'b1);
    b("t5a", 2'b10);
    ram_chk("t5_ram0", 0, 32'h1);
    ram_chk("t5_ram1", 1, 32'h2);
    aw(32'h0, 8'd0, 3'd3, 2'b01);
    w(32'h99, 4'hF, 1'b1);
    b("t5b", 2'b10);
    ram_chk("t5_size_ram0", 0, 32'h1);
    aw(32'h18, 8'd1, 3'd2, 2'b01);
    w(32'h31, 4'hF, 1'b1);
    chk("t5_early_last_no_b", 32'(bus.BVALID), 32'd0);
    w(32'h32, 4'hF, 1'b1);
    b("t5c", 2'b10);
    ram_chk("t5_early_last_ram6", 6, 32'h31);
    aw(32'h20, 8'd0, 3'd2, 2'b01);
    w(32'h41, 4'hF, 1'b0);
    b("t5d", 2'b10);
    ram_chk("t5_missing_last_ram8", 8, 32'h41);

    // T6 BREADY held low, then reset mid-burst
    aw(32'h24, 8'd0, 3'd2, 2'b01);
    w(32'h51, 4'hF, 1'b1);
    bus.AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      chk($sformatf("t6_hold_bvalid%0d", i), 32'(bus.BVALID), 32'd1);
      chk($sformatf("t6_hold_bresp%0d", i), 32'(bus.BRESP), 32'd0);
      chk($sformatf("t6_hold_awready%0d", i), 32'(bus.AWREADY), 32'd0);
    end
    bus.AWVALID = 1'b0;
    b("t6a", 2'b00);
    ram_chk("t6_ram9", 9, 32'h51);
    aw(32'h0, 8'd3, 3'd2, 2'b01);
    w(32'hC1, 4'hF, 1'b0);
    w(32'hC2, 4'hF, 1'b0);
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    chk("t6_rst_wready", 32'(bus.WREADY), 32'd0);
    chk("t6_rst_awready", 32'(bus.AWREADY), 32'd1);
    repeat (3) begin @(posedge ACLK); #1; end
    chk("t6_rst_no_b", 32'(bus.BVALID), 32'd0);
    ram_chk("t6_kept0", 0, 32'hC1);
    ram_chk("t6_kept1", 1, 32'hC2);
    ram_chk("t6_kept2", 2, 32'hA3);

    // Error state must not leak into the next burst
    aw(32'h28, 8'd0, 3'd2, 2'b01);
    w(32'h61, 4'hF, 1'b1);
    b("t7", 2'b00);
    ram_chk("t7_ram10", 10, 32'h61);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

endmodule

`default_nettype wire
